// File: rtl/clip_memory_scheduler.sv
// clip_memory_scheduler
//   Shares the single clip-memory bus (banks 0/1) between the record channel
//   (sample writes) and the play channel (sample reads) so recording and
//   playback can run concurrently. Each channel owns an address counter, a
//   latched clip/bank selection and end-of-clip detection. At most one memory
//   access is issued per cycle. When both channels want the same cycle, the
//   channel that did not win last time gets the bus.
//
// Ports
//   clock_i, reset_i              clock, asynchronous active-low reset
//   rec_start_i / rec_clip_i      start (or restart) recording into clip 0/1
//   rec_req_i / rec_data_i        write request (level) and its sample
//   rec_ack_o / rec_done_o        write issued / last address written
//   play_start_i / play_clip_i    start (or restart) playback of clip 0/1
//   play_req_i                    read request (level)
//   play_ack_o / play_done_o      read issued / last address read issued
//   play_data_o / play_valid_o    read sample, valid two cycles after ack
//   mem_addr_o, mem_wdata_o       shared address / write data to both banks
//   mem_we_o                      1 = write, 0 = read
//   mem_0_en_o, mem_1_en_o        bank enables (at most one high)
//   mem_rdata_i                   muxed bank read data, 1-cycle latency

module clip_memory_scheduler #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int CLIP_DEPTH = 48000
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              rec_start_i,
    input  logic              rec_clip_i,
    input  logic              rec_req_i,
    input  logic [DATA_W-1:0] rec_data_i,
    output logic              rec_ack_o,
    output logic              rec_done_o,
    input  logic              play_start_i,
    input  logic              play_clip_i,
    input  logic              play_req_i,
    output logic              play_ack_o,
    output logic [DATA_W-1:0] play_data_o,
    output logic              play_valid_o,
    output logic              play_done_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_0_en_o,
    output logic              mem_1_en_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_ACTIVE  = 1'b1;

    localparam logic [0:0] GRANT_REC  = 1'b0;
    localparam logic [0:0] GRANT_PLAY = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLIP_DEPTH - 1);

    logic [0:0]        rec_state;
    logic [0:0]        play_state;
    logic [ADDR_W-1:0] rec_count;
    logic [ADDR_W-1:0] play_count;
    logic              rec_clip;
    logic              play_clip;
    logic [0:0]        last_grant;
    logic              read_pending;

    logic rec_eligible;
    logic play_eligible;
    logic grant_rec;
    logic grant_play;
    logic rec_last;
    logic play_last;

    // A channel whose ack is currently high is excluded, so a requester that
    // drops req on seeing ack is never granted twice. A start in the same
    // cycle discards any pending request of that channel.
    always_comb begin
        rec_eligible  = (rec_state == ST_ACTIVE) && rec_req_i && !rec_ack_o && !rec_start_i;
        play_eligible = (play_state == ST_ACTIVE) && play_req_i && !play_ack_o && !play_start_i;
        grant_rec     = rec_eligible && (!play_eligible || (last_grant == GRANT_PLAY));
        grant_play    = play_eligible && !grant_rec;
        rec_last      = (rec_count == LAST_ADDR);
        play_last     = (play_count == LAST_ADDR);
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rec_state    <= ST_IDLE;
            play_state   <= ST_IDLE;
            rec_count    <= '0;
            play_count   <= '0;
            rec_clip     <= 1'b0;
            play_clip    <= 1'b0;
            last_grant   <= GRANT_PLAY;
            read_pending <= 1'b0;
            rec_ack_o    <= 1'b0;
            rec_done_o   <= 1'b0;
            play_ack_o   <= 1'b0;
            play_done_o  <= 1'b0;
            play_data_o  <= '0;
            play_valid_o <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_we_o     <= 1'b0;
            mem_0_en_o   <= 1'b0;
            mem_1_en_o   <= 1'b0;
        end else begin
            rec_ack_o   <= 1'b0;
            rec_done_o  <= 1'b0;
            play_ack_o  <= 1'b0;
            play_done_o <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_0_en_o  <= 1'b0;
            mem_1_en_o  <= 1'b0;

            // Record channel state and address counter
            if (rec_start_i) begin
                rec_state <= ST_ACTIVE;
                rec_count <= '0;
                rec_clip  <= rec_clip_i;
            end else if (grant_rec) begin
                if (rec_last) begin
                    rec_state <= ST_IDLE;
                end else begin
                    rec_count <= rec_count + 1'b1;
                end
            end

            // Play channel state and address counter
            if (play_start_i) begin
                play_state <= ST_ACTIVE;
                play_count <= '0;
                play_clip  <= play_clip_i;
            end else if (grant_play) begin
                if (play_last) begin
                    play_state <= ST_IDLE;
                end else begin
                    play_count <= play_count + 1'b1;
                end
            end

            // Bus drive; address and write data hold when nobody is granted
            if (grant_rec) begin
                rec_ack_o   <= 1'b1;
                rec_done_o  <= rec_last;
                mem_addr_o  <= rec_count;
                mem_wdata_o <= rec_data_i;
                mem_we_o    <= 1'b1;
                mem_0_en_o  <= !rec_clip;
                mem_1_en_o  <= rec_clip;
                last_grant  <= GRANT_REC;
            end else if (grant_play) begin
                play_ack_o  <= 1'b1;
                play_done_o <= play_last;
                mem_addr_o  <= play_count;
                mem_0_en_o  <= !play_clip;
                mem_1_en_o  <= play_clip;
                last_grant  <= GRANT_PLAY;
            end

            // The BRAM samples the address at the edge closing the ack cycle,
            // and its data is captured one edge after that.
            read_pending <= play_ack_o;
            play_valid_o <= read_pending;
            if (read_pending) begin
                play_data_o <= mem_rdata_i;
            end
        end
    end

endmodule
